// File: rtl/track_readout_sched_if.sv
// Read bus shared by the track buffers and the tagged track output bus.
// The scheduler drives the master side; the buffers and the consumer sit on the slave side.
interface track_readout_sched_if #(
  parameter int NSRC   = 4,
  parameter int DATA_W = 126
);
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [7:0]             read_add;
  logic [6*NSRC-1:0]      number_in;
  logic [DATA_W*NSRC-1:0] data_in;
  logic [DATA_W-1:0]      data_out;
  logic                   valid_out;
  logic [SRC_W-1:0]       src_out;

  modport master (
    output read_add, data_out, valid_out, src_out,
    input  number_in, data_in
  );
  modport slave (
    input  read_add, data_out, valid_out, src_out,
    output number_in, data_in
  );
endinterface

// File: rtl/track_readout_sched.sv
// Per-BX round-robin readout of NSRC track buffers through one broadcast read address.
// Words left unread when the next BX start arrives are counted in trunc_cnt.
module track_readout_sched #(
  parameter int NSRC   = 4,
  parameter int TMUX   = 18,
  parameter int RD_LAT = 1,
  parameter int MAXTRK = 32,
  parameter int DATA_W = 126
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_proc,
  input  logic [1:0]           start,
  output logic [1:0]           done,
  output logic [15:0]          trunc_cnt,
  track_readout_sched_if.master bus
);
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CNT, S_CNT_WAIT, S_READ, S_DRAIN, S_NEXT} state_t;

  state_t           r_state;
  logic [2:0]       r_bx_ctr;
  logic [2:0]       r_rd_bx;
  logic [SRC_W-1:0] r_rr_start;
  logic [SRC_W-1:0] r_cur_src;
  logic [SRC_W-1:0] r_served;
  logic [5:0]       r_n;
  logic [5:0]       r_idx;
  logic [3:0]       r_wait;
  logic [5:0]       r_left [NSRC];
  logic             r_cnt_ok;
  logic [7:0]       r_read_add;
  logic [15:0]      r_trunc;
  logic             r_vld_p0;
  logic [SRC_W-1:0] r_src_p0;
  logic             r_vld_p1 [RD_LAT];
  logic [SRC_W-1:0] r_src_p1 [RD_LAT];
  logic [1:0]       r_done_p [TMUX];
  logic [15:0]      w_left_sum;
  logic [5:0]       w_num_cur;

  function automatic logic [5:0] clamp_cnt(input logic [5:0] c);
    return (c > 6'(MAXTRK)) ? 6'(MAXTRK) : c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(NSRC - 1)) ? '0 : s + 1'b1;
  endfunction

  always_comb begin
    w_left_sum = '0;
    for (int s = 0; s < NSRC; s++) w_left_sum = w_left_sum + 16'(r_left[s]);
    w_num_cur = clamp_cnt(bus.number_in[6*int'(r_cur_src) +: 6]);
  end

  assign bus.read_add = r_read_add;
  assign trunc_cnt    = r_trunc;
  assign done         = r_done_p[TMUX-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TMUX; i++) r_done_p[i] <= '0;
    end else begin
      r_done_p[0] <= start;
      for (int i = 1; i < TMUX; i++) r_done_p[i] <= r_done_p[i-1];
    end
  end

  // Scheduler FSM: issue stage (_p0)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bx_ctr   <= 3'b111;
      r_rd_bx    <= '0;
      r_rr_start <= '0;
      r_cur_src  <= '0;
      r_served   <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_wait     <= '0;
      r_cnt_ok   <= 1'b0;
      r_read_add <= '0;
      r_trunc    <= '0;
      r_vld_p0   <= 1'b0;
      r_src_p0   <= '0;
      for (int s = 0; s < NSRC; s++) r_left[s] <= '0;
    end else if (start[1]) begin
      r_state    <= S_IDLE;
      r_bx_ctr   <= 3'b111;
      r_rd_bx    <= '0;
      r_rr_start <= '0;
      r_cur_src  <= '0;
      r_served   <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_wait     <= '0;
      r_cnt_ok   <= 1'b0;
      r_read_add <= '0;
      r_vld_p0   <= 1'b0;
      r_src_p0   <= '0;
      for (int s = 0; s < NSRC; s++) r_left[s] <= '0;
    end else if (start[0]) begin
      // Whatever is still unread from the previous BX is lost here.
      r_trunc    <= sat_add16(r_trunc, w_left_sum);
      r_bx_ctr   <= r_bx_ctr + 3'd1;
      r_rd_bx    <= r_bx_ctr;
      r_cur_src  <= r_rr_start;
      r_rr_start <= next_src(r_rr_start);
      r_served   <= '0;
      r_cnt_ok   <= 1'b0;
      r_read_add <= {r_bx_ctr, 5'b0};
      r_vld_p0   <= 1'b0;
      r_state    <= S_CNT;
      for (int s = 0; s < NSRC; s++) r_left[s] <= '0;
    end else if (en_proc) begin
      r_vld_p0 <= 1'b0;
      case (r_state)
        S_IDLE: ;
        S_CNT: begin
          r_wait  <= '0;
          r_state <= S_CNT_WAIT;
        end
        S_CNT_WAIT: begin
          if (r_wait == 4'(RD_LAT - 1)) begin
            // The count read is broadcast, so the first one of a BX gives every source's backlog.
            if (!r_cnt_ok) begin
              for (int s = 0; s < NSRC; s++) r_left[s] <= clamp_cnt(bus.number_in[6*s +: 6]);
            end
            r_left[r_cur_src] <= w_num_cur;
            r_cnt_ok <= 1'b1;
            r_n      <= w_num_cur;
            r_idx    <= '0;
            r_state  <= (w_num_cur == 6'd0) ? S_NEXT : S_READ;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_READ: begin
          r_read_add        <= {r_rd_bx, r_idx[4:0]};
          r_vld_p0          <= 1'b1;
          r_src_p0          <= r_cur_src;
          r_idx             <= r_idx + 6'd1;
          r_left[r_cur_src] <= r_left[r_cur_src] - 6'd1;
          if (r_idx == r_n - 6'd1) begin
            r_wait  <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_wait == 4'(RD_LAT - 1)) r_state <= S_NEXT;
          else r_wait <= r_wait + 4'd1;
        end
        S_NEXT: begin
          if (r_served == SRC_W'(NSRC - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cur_src  <= next_src(r_cur_src);
            r_served   <= r_served + 1'b1;
            r_read_add <= {r_rd_bx, 5'b0};
            r_state    <= S_CNT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      r_vld_p0 <= 1'b0;
    end
  end

  // Read-latency alignment (_p1) and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || start[1]) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld_p1[i] <= 1'b0;
        r_src_p1[i] <= '0;
      end
      bus.valid_out <= 1'b0;
      bus.src_out   <= '0;
      bus.data_out  <= '0;
    end else begin
      r_vld_p1[0] <= r_vld_p0;
      r_src_p1[0] <= r_src_p0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p1[i] <= r_vld_p1[i-1];
        r_src_p1[i] <= r_src_p1[i-1];
      end
      bus.valid_out <= r_vld_p1[RD_LAT-1];
      bus.src_out   <= r_src_p1[RD_LAT-1];
      if (r_vld_p1[RD_LAT-1])
        bus.data_out <= bus.data_in[DATA_W*int'(r_src_p1[RD_LAT-1]) +: DATA_W];
    end
  end
endmodule
